byte_memory: RTL and testbench

- Byte-addressable 32-bit memory built from MEM_BANKS interleaved byte-wide banks, with per-byte strobes, fixed read/write latency and optional burst.
- Serves as the simulation/SoC backing memory behind a simple busy-handshake bus.
- There is no request-valid signal: whenever the block is idle, it samples the bus and starts an operation.

---
 rtl/byte_memory_if.sv | 36 +++
 rtl/byte_memory.sv | 129 ++++++++++++
 tb/tb_byte_memory.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/byte_memory_if.sv
// Bus between a requester and byte_memory: start address, write data, byte
// strobes, direction, burst length, plus busy and read-data return.
interface byte_memory_if #(
    parameter int unsigned MEM_ADDR_SIZE   = 32,
    parameter int unsigned MEM_WORD_SIZE   = 32,
    parameter int unsigned MEM_STROBE_BITS = 4,
    parameter int unsigned BURST_BITS      = 2
);
    logic [MEM_ADDR_SIZE-1:0]   memAddr;
    logic [MEM_WORD_SIZE-1:0]   memDataIn;
    logic [MEM_STROBE_BITS-1:0] memStrb;
    logic                       memWr;
    logic [BURST_BITS-1:0]      memBurstLen;
    logic                       memBusyOut;
    logic [MEM_WORD_SIZE-1:0]   memDataOut;

    modport master (
        output memAddr,
        output memDataIn,
        output memStrb,
        output memWr,
        output memBurstLen,
        input  memBusyOut,
        input  memDataOut
    );

    modport slave (
        input  memAddr,
        input  memDataIn,
        input  memStrb,
        input  memWr,
        input  memBurstLen,
        output memBusyOut,
        output memDataOut
    );
endinterface

// File: rtl/byte_memory.sv
// Byte-addressable word memory built from interleaved byte-wide banks.
// Idle lasts one cycle: the bus is sampled and an operation of
// memBurstLen+1 beats starts, each beat taking a fixed latency.
module byte_memory #(
    parameter int unsigned MEM_ADDR_SIZE       = 32,
    parameter int unsigned MEM_WORD_SIZE       = 32,
    parameter int unsigned MEM_STROBE_BITS     = 4,
    parameter int unsigned BURST_BITS          = 2,
    parameter int unsigned MEM_BANK_BITS       = 2,
    parameter int unsigned MEM_BANK_WORD_SIZE  = 8,
    parameter int unsigned MEM_BANK_DEPTH_BITS = 10,
    parameter int unsigned MEM_WR_LATENCY      = 2,
    parameter int unsigned MEM_RD_LATENCY      = 2
) (
    input  logic         clk,
    input  logic         reset,
    byte_memory_if.slave bus
);
    localparam int unsigned MEM_BANKS      = 1 << MEM_BANK_BITS;
    localparam int unsigned MEM_BANK_DEPTH = 1 << MEM_BANK_DEPTH_BITS;
    localparam int unsigned LANE_ADDR_BITS = MEM_BANK_BITS + MEM_BANK_DEPTH_BITS;
    localparam int unsigned LAT_MAX        = (MEM_WR_LATENCY > MEM_RD_LATENCY) ?
                                             MEM_WR_LATENCY : MEM_RD_LATENCY;
    localparam int unsigned LAT_BITS       = ($clog2(LAT_MAX) > 0) ? $clog2(LAT_MAX) : 1;
    localparam logic [LAT_BITS-1:0] WR_RELOAD = LAT_BITS'(MEM_WR_LATENCY - 1);
    localparam logic [LAT_BITS-1:0] RD_RELOAD = LAT_BITS'(MEM_RD_LATENCY - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t                      state_q;
    logic [LANE_ADDR_BITS-1:0]   addr_q;
    logic [MEM_WORD_SIZE-1:0]    data_q;
    logic [MEM_STROBE_BITS-1:0]  strb_q;
    logic                        wr_q;
    logic [BURST_BITS-1:0]       beat_q;
    logic [LAT_BITS-1:0]         lat_q;
    logic                        busy_q;
    logic [MEM_WORD_SIZE-1:0]    rdata_q;

    logic [MEM_BANK_WORD_SIZE-1:0] mem_q [MEM_BANKS][MEM_BANK_DEPTH];

    logic [LANE_ADDR_BITS-1:0]   lane_addr [MEM_STROBE_BITS];
    logic [MEM_WORD_SIZE-1:0]    rdata_d;
    logic                        beat_go;

    // Address bits above the bank/row range do not select storage.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.memAddr[MEM_ADDR_SIZE-1:LANE_ADDR_BITS];

    assign beat_go        = (state_q == BUSY) && (lat_q == '0);
    assign bus.memBusyOut = busy_q;
    assign bus.memDataOut = rdata_q;

    // Per-lane byte address (wraps within the bank array) and strobed read word.
    always_comb begin
        rdata_d = '0;
        for (int unsigned i = 0; i < MEM_STROBE_BITS; i++) begin
            lane_addr[i] = addr_q + LANE_ADDR_BITS'(i);
            if (strb_q[i]) begin
                rdata_d[i*MEM_BANK_WORD_SIZE +: MEM_BANK_WORD_SIZE] =
                    mem_q[lane_addr[i][MEM_BANK_BITS-1:0]]
                         [lane_addr[i][LANE_ADDR_BITS-1:MEM_BANK_BITS]];
            end
        end
    end

    // Bank storage: never reset; written only when a write beat completes.
    always_ff @(posedge clk) begin
        if (beat_go && wr_q) begin
            for (int unsigned i = 0; i < MEM_STROBE_BITS; i++) begin
                if (strb_q[i]) begin
                    mem_q[lane_addr[i][MEM_BANK_BITS-1:0]]
                         [lane_addr[i][LANE_ADDR_BITS-1:MEM_BANK_BITS]]
                        <= data_q[i*MEM_BANK_WORD_SIZE +: MEM_BANK_WORD_SIZE];
                end
            end
        end
    end

    // Control FSM: capture request in IDLE, count latency and beats in BUSY.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            wr_q    <= 1'b0;
            beat_q  <= '0;
            lat_q   <= '0;
            busy_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    addr_q  <= bus.memAddr[LANE_ADDR_BITS-1:0];
                    data_q  <= bus.memDataIn;
                    strb_q  <= bus.memStrb;
                    wr_q    <= bus.memWr;
                    beat_q  <= bus.memBurstLen;
                    lat_q   <= bus.memWr ? WR_RELOAD : RD_RELOAD;
                    busy_q  <= 1'b1;
                    state_q <= BUSY;
                end
                BUSY: begin
                    if (lat_q != '0) begin
                        lat_q <= lat_q - LAT_BITS'(1);
                    end else begin
                        if (!wr_q) begin
                            rdata_q <= rdata_d;
                        end
                        if (beat_q != '0) begin
                            beat_q <= beat_q - BURST_BITS'(1);
                            addr_q <= addr_q + LANE_ADDR_BITS'(MEM_STROBE_BITS);
                            lat_q  <= wr_q ? WR_RELOAD : RD_RELOAD;
                            data_q <= bus.memDataIn;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_byte_memory.sv
// Directed bench for byte_memory: reset, word sweep, strobes, unaligned
// lanes, address wrap, bursts and reset abort in mid-burst.
module tb_byte_memory;
    logic clk = 1'b0;
    logic reset;
    int   vectors     = 0;
    int   miscompares = 0;

    typedef logic [3:0][31:0] quad_t;

    byte_memory_if bus ();

    byte_memory #(
        .MEM_ADDR_SIZE      (32),
        .MEM_WORD_SIZE      (32),
        .MEM_STROBE_BITS    (4),
        .BURST_BITS         (2),
        .MEM_BANK_BITS      (2),
        .MEM_BANK_WORD_SIZE (8),
        .MEM_BANK_DEPTH_BITS(10),
        .MEM_WR_LATENCY     (2),
        .MEM_RD_LATENCY     (2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Follows one operation from its start edge. Called just after a negedge
    // in IDLE; returns at the negedge where busy is seen low. Supplies the
    // next beat's write data before each beat boundary and records
    // memDataOut after each beat.
    task automatic wait_op(input int burst, input quad_t d,
                           output int busy_cycles, output quad_t rd);
        bit done;
        busy_cycles = 0;
        rd          = '0;
        done        = 1'b0;
        for (int n = 1; n <= 64 && !done; n++) begin
            @(negedge clk);
            if ((n % 2 == 1) && n >= 3 && ((n - 3) / 2) <= 3)
                rd[(n - 3) / 2] = bus.memDataOut;
            if (bus.memBusyOut) begin
                busy_cycles++;
                if ((n % 2 == 1) && ((n + 1) / 2) <= burst)
                    bus.memDataIn = d[(n + 1) / 2];
            end else begin
                done = 1'b1;
            end
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL busy_timeout: busy still %b after 64 cycles, required 0", bus.memBusyOut);
        end
    endtask

    task automatic run_op(input logic [31:0] addr, input logic wr, input logic [3:0] strb,
                          input int burst, input quad_t d,
                          output int busy_cycles, output quad_t rd);
        bus.memAddr     = addr;
        bus.memWr       = wr;
        bus.memStrb     = strb;
        bus.memBurstLen = 2'(burst);
        bus.memDataIn   = d[0];
        wait_op(burst, d, busy_cycles, rd);
    endtask

    task automatic test_reset();
        int    cyc;
        quad_t rd;
        reset           = 1'b0;
        bus.memAddr     = '0;
        bus.memWr       = 1'b0;
        bus.memStrb     = 4'h0;
        bus.memBurstLen = 2'd0;
        bus.memDataIn   = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.memBusyOut !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy: got %b, required 0", bus.memBusyOut);
        end
        vectors++;
        if (bus.memDataOut !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_dout: got %h, required 00000000", bus.memDataOut);
        end
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wait_op(0, '0, cyc, rd);
            vectors++;
            if (cyc != 2) begin
                miscompares++;
                $display("FAIL idle_busy_cycles[%0d]: got %0d, required 2", k, cyc);
            end
            vectors++;
            if (rd[0] !== 32'h0) begin
                miscompares++;
                $display("FAIL idle_dout[%0d]: got %h, required 00000000", k, rd[0]);
            end
        end
    endtask

    task automatic test_write_sweep();
        int    cyc;
        quad_t rd;
        quad_t d;
        for (int unsigned i = 0; i < 8; i++) begin
            d    = '0;
            d[0] = 32'hC0DE0000 + i * 32'h00010101;
            run_op(i * 4, 1'b1, 4'hF, 0, d, cyc, rd);
            vectors++;
            if (cyc != 2) begin
                miscompares++;
                $display("FAIL sweep_wr_busy[%0d]: got %0d, required 2", i, cyc);
            end
        end
        for (int unsigned i = 0; i < 8; i++) begin
            run_op(i * 4, 1'b0, 4'hF, 0, '0, cyc, rd);
            vectors++;
            if (rd[0] !== 32'hC0DE0000 + i * 32'h00010101 || cyc != 2) begin
                miscompares++;
                $display("FAIL sweep_rd[%0d]: got %h (busy %0d), required %h (busy 2)",
                         i, rd[0], cyc, 32'hC0DE0000 + i * 32'h00010101);
            end
        end
    endtask

    task automatic test_partial_strobe();
        int    cyc;
        quad_t rd;
        quad_t d;
        d = '0; d[0] = 32'hAABBCCDD;
        run_op(32'h40, 1'b1, 4'hF, 0, d, cyc, rd);
        d = '0; d[0] = 32'h11223344;
        run_op(32'h40, 1'b1, 4'b0101, 0, d, cyc, rd);
        run_op(32'h40, 1'b0, 4'hF, 0, '0, cyc, rd);
        vectors++;
        if (rd[0] !== 32'hAA22CC44) begin
            miscompares++;
            $display("FAIL partial_merge: got %h, required aa22cc44", rd[0]);
        end
        run_op(32'h40, 1'b0, 4'b0011, 0, '0, cyc, rd);
        vectors++;
        if (rd[0] !== 32'h0000CC44) begin
            miscompares++;
            $display("FAIL partial_read_mask: got %h, required 0000cc44", rd[0]);
        end
        d = '0; d[0] = 32'h99999999;
        run_op(32'h44, 1'b1, 4'hF, 0, d, cyc, rd);
        vectors++;
        if (rd[0] !== 32'h0000CC44) begin
            miscompares++;
            $display("FAIL dout_hold_on_write: got %h, required 0000cc44", rd[0]);
        end
    endtask

    task automatic test_unaligned();
        int    cyc;
        quad_t rd;
        quad_t d;
        d = '0;
        run_op(32'h80, 1'b1, 4'hF, 0, d, cyc, rd);
        run_op(32'h84, 1'b1, 4'hF, 0, d, cyc, rd);
        d[0] = 32'h01020304;
        run_op(32'h81, 1'b1, 4'hF, 0, d, cyc, rd);
        run_op(32'h80, 1'b0, 4'hF, 0, '0, cyc, rd);
        vectors++;
        if (rd[0] !== 32'h02030400) begin
            miscompares++;
            $display("FAIL unaligned_lo: got %h, required 02030400", rd[0]);
        end
        run_op(32'h84, 1'b0, 4'hF, 0, '0, cyc, rd);
        vectors++;
        if (rd[0] !== 32'h00000001) begin
            miscompares++;
            $display("FAIL unaligned_hi: got %h, required 00000001", rd[0]);
        end
    endtask

    // Runs after the sweep: word 0 holds c0de0000 before this overwrite.
    task automatic test_wrap();
        int    cyc;
        quad_t rd;
        quad_t d;
        d = '0; d[0] = 32'hA1B2C3D4;
        run_op(32'h00000FFF, 1'b1, 4'hF, 0, d, cyc, rd);
        run_op(32'h00000000, 1'b0, 4'hF, 0, '0, cyc, rd);
        vectors++;
        if (rd[0] !== 32'hC0A1B2C3) begin
            miscompares++;
            $display("FAIL wrap_low_word: got %h, required c0a1b2c3", rd[0]);
        end
        run_op(32'h10000FFC, 1'b0, 4'b1000, 0, '0, cyc, rd);
        vectors++;
        if (rd[0] !== 32'hD4000000) begin
            miscompares++;
            $display("FAIL wrap_upper_bits: got %h, required d4000000", rd[0]);
        end
    endtask

    task automatic test_burst();
        int    cyc;
        quad_t rd;
        quad_t d;
        d[0] = 32'h0BADF00D;
        d[1] = 32'h12345678;
        d[2] = 32'h9ABCDEF0;
        d[3] = 32'h0F1E2D3C;
        run_op(32'h100, 1'b1, 4'hF, 3, d, cyc, rd);
        vectors++;
        if (cyc != 8) begin
            miscompares++;
            $display("FAIL burst_wr_busy: got %0d, required 8", cyc);
        end
        run_op(32'h100, 1'b0, 4'hF, 3, '0, cyc, rd);
        vectors++;
        if (cyc != 8) begin
            miscompares++;
            $display("FAIL burst_rd_busy: got %0d, required 8", cyc);
        end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (rd[k] !== d[k]) begin
                miscompares++;
                $display("FAIL burst_rd_beat[%0d]: got %h, required %h", k, rd[k], d[k]);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int    cyc;
        quad_t rd;
        quad_t p;
        quad_t e;
        for (int k = 0; k < 4; k++) begin
            p[k] = 32'h5A5A0000 + 32'(k);
            e[k] = 32'hE0000000 + 32'(k) * 32'h00001111;
        end
        run_op(32'h200, 1'b1, 4'hF, 3, p, cyc, rd);
        run_op(32'h200, 1'b0, 4'hF, 0, '0, cyc, rd);
        vectors++;
        if (rd[0] !== 32'h5A5A0000) begin
            miscompares++;
            $display("FAIL abort_pre_read: got %h, required 5a5a0000", rd[0]);
        end
        bus.memAddr     = 32'h200;
        bus.memWr       = 1'b1;
        bus.memStrb     = 4'hF;
        bus.memBurstLen = 2'd3;
        bus.memDataIn   = e[0];
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            if ((n % 2 == 1) && ((n + 1) / 2) <= 3)
                bus.memDataIn = e[(n + 1) / 2];
        end
        vectors++;
        if (bus.memBusyOut !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_busy_before: got %b, required 1", bus.memBusyOut);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (bus.memBusyOut !== 1'b0 || bus.memDataOut !== 32'h0) begin
            miscompares++;
            $display("FAIL abort_async: got busy %b dout %h, required busy 0 dout 00000000",
                     bus.memBusyOut, bus.memDataOut);
        end
        @(negedge clk);
        bus.memAddr     = 32'h200;
        bus.memWr       = 1'b0;
        bus.memStrb     = 4'hF;
        bus.memBurstLen = 2'd3;
        @(negedge clk);
        reset = 1'b1;
        wait_op(3, '0, cyc, rd);
        vectors++;
        if (cyc != 8) begin
            miscompares++;
            $display("FAIL abort_rd_busy: got %0d, required 8", cyc);
        end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (rd[k] !== ((k < 2) ? e[k] : p[k])) begin
                miscompares++;
                $display("FAIL abort_rd_beat[%0d]: got %h, required %h",
                         k, rd[k], (k < 2) ? e[k] : p[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_sweep();
        test_partial_strobe();
        test_unaligned();
        test_wrap();
        test_burst();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end
endmodule
